joybus_device: RTL and testbench

Controller-side JOYBUS responder for N64/GC-style pads. It receives the host's one-byte command on the shared open-drain `JB` line and answers with the controller's status or button word, bit-timed like a real pad. It lets the FPGA stand in for a controller behind `JOYBUS_host` and gives the team a loopback target for the host in simulation.

---
 rtl/joybus_pkg.sv | 44 ++++
 rtl/jb_sync.sv | 28 ++
 rtl/joybus_device.sv | 148 ++++++++++++++
 tb/tb_joybus_device.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// Shared JOYBUS command codes, controller status bytes and responder state encoding.
package joybus_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] STATUS_B0 = 8'h05;
    localparam logic [7:0] STATUS_B1 = 8'h00;
    localparam logic [7:0] STATUS_B2 = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StRxLow,
        StRxHigh,
        StTurn,
        StTxLow,
        StTxHigh,
        StTxStop
    } dev_state_t;

    // Number of response bits for a command; zero means the command is not answered.
    function automatic logic [5:0] resp_bits(input logic [7:0] cmd);
        logic [5:0] n;
        case (cmd)
            CMD_STATUS, CMD_RESET: n = 6'd24;
            CMD_POLL:              n = 6'd32;
            default:               n = 6'd0;
        endcase
        return n;
    endfunction

    // Response word, MSB-aligned so the transmitter always shifts out bit 31 first.
    function automatic logic [31:0] resp_word(input logic [7:0] cmd, input logic [31:0] btn);
        logic [31:0] w;
        case (cmd)
            CMD_STATUS, CMD_RESET: w = {STATUS_B0, STATUS_B1, STATUS_B2, 8'h00};
            CMD_POLL:              w = btn;
            default:               w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/jb_sync.sv
// Two-flop synchronizer for the JOYBUS line with rise/fall strobes.
module jb_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic jb_s;

    // Idle line is pulled high, so reset to 1 to avoid a false falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            jb_s   <= 1'b1;
        end else begin
            meta_q <= din;
            jb_s   <= meta_q;
        end
    end

    // Strobes flag the edge jb_s takes on the coming clock, keeping total RX lag at 2 cycles.
    assign rise = meta_q & ~jb_s;
    assign fall = ~meta_q & jb_s;

endmodule

// File: rtl/joybus_device.sv
// JOYBUS controller responder: decodes a host command byte and answers with status or buttons.
module joybus_device
    import joybus_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 25,
    parameter int unsigned TURN_US       = 2,
    parameter int unsigned TIMEOUT_US    = 8
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         JB,
    input  logic [31:0] btn_state,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy,
    output logic        rx_err
);

    localparam int unsigned TimeoutCyc = TIMEOUT_US * CYCLES_PER_US;
    localparam int unsigned CntW       = $clog2(TimeoutCyc) + 1;

    localparam logic [CntW-1:0] OneUs      = CntW'(CYCLES_PER_US);
    localparam logic [CntW-1:0] ThreeUs    = CntW'(3 * CYCLES_PER_US);
    localparam logic [CntW-1:0] SampleCyc  = CntW'(2 * CYCLES_PER_US);
    localparam logic [CntW-1:0] StopLast   = CntW'(2 * CYCLES_PER_US - 1);
    localparam logic [CntW-1:0] TurnLast   = CntW'(TURN_US * CYCLES_PER_US - 1);
    localparam logic [CntW-1:0] TmoLast    = CntW'(TimeoutCyc - 1);

    dev_state_t      state_q;
    logic [CntW-1:0] cnt_q;
    logic [5:0]      bits_q;
    logic [7:0]      rx_sr_q;
    logic [31:0]     tx_sr_q;
    logic            drv_low_q;

    logic            jb_rise;
    logic            jb_fall;
    logic [CntW-1:0] low_last;
    logic [CntW-1:0] high_last;

    jb_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (JB),
        .rise (jb_rise),
        .fall (jb_fall)
    );

    assign JB   = drv_low_q ? 1'b0 : 1'bz;
    assign busy = (state_q != StIdle);

    // A 1 is a short low and long release; a 0 the reverse.
    assign low_last  = (tx_sr_q[31] ? OneUs : ThreeUs) - 1'b1;
    assign high_last = (tx_sr_q[31] ? ThreeUs : OneUs) - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bits_q    <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            drv_low_q <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            rx_err    <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            rx_err    <= 1'b0;
            cnt_q     <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (jb_fall) begin
                        state_q <= StRxLow;
                        cnt_q   <= '0;
                        bits_q  <= '0;
                    end
                end
                StRxLow: begin
                    // Timeout wins over any edge seen on the same cycle.
                    if (cnt_q >= TmoLast) begin
                        rx_err  <= 1'b1;
                        state_q <= StIdle;
                    end else if (jb_rise) begin
                        cnt_q <= '0;
                        if (bits_q == 6'd8) begin
                            cmd_valid <= 1'b1;
                            cmd_byte  <= rx_sr_q;
                            tx_sr_q   <= resp_word(rx_sr_q, btn_state);
                            bits_q    <= resp_bits(rx_sr_q);
                            state_q   <= StTurn;
                        end else begin
                            // Rising before the 2 us sample point means the line read high.
                            rx_sr_q <= {rx_sr_q[6:0], (cnt_q < SampleCyc)};
                            bits_q  <= bits_q + 6'd1;
                            state_q <= StRxHigh;
                        end
                    end
                end
                StRxHigh: begin
                    if (cnt_q >= TmoLast) begin
                        rx_err  <= 1'b1;
                        state_q <= StIdle;
                    end else if (jb_fall) begin
                        cnt_q   <= '0;
                        state_q <= StRxLow;
                    end
                end
                StTurn: begin
                    if (bits_q == 6'd0) begin
                        state_q <= StIdle;
                    end else if (cnt_q == TurnLast) begin
                        cnt_q     <= '0;
                        drv_low_q <= 1'b1;
                        state_q   <= StTxLow;
                    end
                end
                StTxLow: begin
                    if (cnt_q == low_last) begin
                        cnt_q     <= '0;
                        drv_low_q <= 1'b0;
                        state_q   <= StTxHigh;
                    end
                end
                StTxHigh: begin
                    if (cnt_q == high_last) begin
                        cnt_q     <= '0;
                        drv_low_q <= 1'b1;
                        tx_sr_q   <= {tx_sr_q[30:0], 1'b0};
                        bits_q    <= bits_q - 6'd1;
                        state_q   <= (bits_q == 6'd1) ? StTxStop : StTxLow;
                    end
                end
                StTxStop: begin
                    if (cnt_q == StopLast) begin
                        drv_low_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    drv_low_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_device.sv
// Scoreboard bench for joybus_device: a host model drives commands, a line monitor decodes replies.
module tb_joybus_device;
    import joybus_pkg::*;

    localparam int CPU = 25;

    typedef struct {
        int          nbits;
        logic [31:0] data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] btn_state = 32'h0;
    logic        host_low = 1'b0;
    bit          host_active = 1'b0;
    wire         jb;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        rx_err;

    assign jb = host_low ? 1'b0 : 1'bz;
    pullup (jb);

    joybus_device #(
        .CYCLES_PER_US (CPU),
        .TURN_US       (2),
        .TIMEOUT_US    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .JB        (jb),
        .btn_state (btn_state),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .busy      (busy),
        .rx_err    (rx_err)
    );

    always #20 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_frames[$];
    logic [7:0] exp_cmds[$];

    task automatic check(input string name, input bit ok, input logic [63:0] act,
                         input logic [63:0] expv);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Host model: 1 = 1 us low / 3 us high, 0 = 3 us low / 1 us high, stop = 1 us low.
    task automatic host_bits(input logic [7:0] b, input int n, input bit stop,
                             output int unsigned rise_cyc);
        bit v;
        rise_cyc = 0;
        host_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            v = b[7-i];
            host_low = 1'b1;
            repeat (v ? CPU : 3 * CPU) tick();
            host_low = 1'b0;
            rise_cyc = cyc;
            repeat (v ? 3 * CPU : CPU) tick();
        end
        if (stop) begin
            host_low = 1'b1;
            repeat (CPU) tick();
            host_low = 1'b0;
            tick();
        end
        host_active = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int unsigned dummy;
        host_bits(b, 8, 1'b1, dummy);
    endtask

    task automatic expect_frame(input int nbits, input logic [31:0] data);
        frame_t f;
        f.nbits = nbits;
        f.data  = data;
        exp_frames.push_back(f);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            tick();
            if (exp_frames.size() == 0 && !busy) done = 1'b1;
        end
        check(name, done, exp_frames.size(), 0);
        repeat (20) tick();
    endtask

    // Line monitor: decodes DUT replies and pops the scoreboard on every command/frame.
    bit          prev_jb = 1'b1;
    bit          in_frame = 1'b0;
    bit          tbad;
    bit          cur;
    int          run_len;
    int          last_low;
    int          nbits;
    logic [31:0] acc;
    int unsigned valid_cyc = 0;
    int unsigned err_cyc = 0;
    int          err_cnt = 0;

    initial begin
        frame_t     f;
        logic [7:0] ec;
        forever begin
            @(negedge clk);
            cur = (jb === 1'b0) ? 1'b0 : 1'b1;
            if (rst) begin
                in_frame = 1'b0;
                prev_jb  = 1'b1;
            end else begin
                if (cmd_valid) begin
                    valid_cyc = cyc;
                    if (exp_cmds.size() == 0) begin
                        check("cmd_unexpected", 1'b0, cmd_byte, 0);
                    end else begin
                        ec = exp_cmds.pop_front();
                        check("cmd_byte", cmd_byte == ec, cmd_byte, ec);
                    end
                end
                if (rx_err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (host_active) begin
                    prev_jb = cur;
                end else begin
                    if (prev_jb && !cur) begin
                        if (!in_frame) begin
                            in_frame = 1'b1;
                            nbits    = 0;
                            acc      = '0;
                            tbad     = 1'b0;
                            check("turn_gap", cyc - valid_cyc == 50, cyc - valid_cyc, 50);
                        end else if (run_len != 4 * CPU - last_low) begin
                            tbad = 1'b1;
                        end
                        run_len = 1;
                    end else if (!prev_jb && cur && in_frame) begin
                        if (run_len == CPU) begin
                            acc = {acc[30:0], 1'b1};
                            nbits++;
                        end else if (run_len == 3 * CPU) begin
                            acc = {acc[30:0], 1'b0};
                            nbits++;
                        end else if (run_len == 2 * CPU) begin
                            in_frame = 1'b0;
                            if (exp_frames.size() == 0) begin
                                check("frame_unexpected", 1'b0, acc, 0);
                            end else begin
                                f = exp_frames.pop_front();
                                check("frame_len", nbits == f.nbits, nbits, f.nbits);
                                check("frame_data", acc == f.data, acc, f.data);
                                check("frame_timing", !tbad, tbad, 0);
                            end
                        end else begin
                            tbad = 1'b1;
                        end
                        last_low = run_len;
                        run_len  = 1;
                    end else begin
                        run_len++;
                    end
                    prev_jb = cur;
                end
            end
        end
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          lows;
        int unsigned rise_cyc;

        // Reset values
        repeat (5) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid == 1'b0, cmd_valid, 0);
        check("rst_rx_err", rx_err == 1'b0, rx_err, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        check("rst_cmd_byte", cmd_byte == 8'h00, cmd_byte, 8'h00);
        check("rst_line", jb === 1'b1, jb, 1);
        repeat (10) tick();

        // Poll with buttons
        btn_state = 32'h8000_1234;
        exp_cmds.push_back(8'h01);
        expect_frame(32, 32'h8000_1234);
        send_cmd(8'h01);
        wait_idle("poll_done");

        // Status and reset commands
        exp_cmds.push_back(8'h00);
        expect_frame(24, 32'h0005_0002);
        send_cmd(8'h00);
        wait_idle("status_done");
        exp_cmds.push_back(8'hFF);
        expect_frame(24, 32'h0005_0002);
        send_cmd(8'hFF);
        wait_idle("reset_cmd_done");

        // Unknown command: no reply, busy drops right after cmd_valid
        exp_cmds.push_back(8'h40);
        send_cmd(8'h40);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        check("unk_cmd_valid", seen, seen, 1);
        @(negedge clk);
        check("unk_busy_drop", busy == 1'b0, busy, 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (jb === 1'b0) lows++;
        end
        check("unk_line_quiet", lows == 0, lows, 0);

        // Abort: 5 bits then the line stays high
        host_bits(8'b1011_0000, 5, 1'b0, rise_cyc);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (rx_err) seen = 1'b1;
        end
        check("abort_rx_err", seen, seen, 1);
        check("abort_rx_err_time", (err_cyc - rise_cyc >= 198) && (err_cyc - rise_cyc <= 206),
              err_cyc - rise_cyc, 200);
        check("abort_cmd_hold", cmd_byte == 8'h40, cmd_byte, 8'h40);
        check("abort_busy", busy == 1'b0, busy, 0);
        repeat (50) tick();

        // Buttons change mid-reply; the latched word must still go out
        btn_state = 32'hFFFF_FFFF;
        exp_cmds.push_back(8'h01);
        expect_frame(32, 32'hFFFF_FFFF);
        send_cmd(8'h01);
        repeat (100) tick();
        btn_state = 32'h0;
        wait_idle("latch_done");

        // Reset during the 10th reply bit (a 0, so the line is low)
        btn_state = 32'h8000_1234;
        exp_cmds.push_back(8'h01);
        send_cmd(8'h01);
        repeat (960) tick();
        @(negedge clk);
        check("mid_tx_low", jb === 1'b0, jb, 0);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_release", jb === 1'b1, jb, 1);
        check("rst_tx_busy", busy == 1'b0, busy, 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // Normal poll after the reset
        exp_cmds.push_back(8'h01);
        expect_frame(32, 32'h8000_1234);
        send_cmd(8'h01);
        wait_idle("post_rst_done");

        check("scoreboard_empty", exp_frames.size() == 0 && exp_cmds.size() == 0,
              exp_frames.size() + exp_cmds.size(), 0);
        check("rx_err_count", err_cnt == 1, err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
